// File: rtl/l2_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : l2_port_arbiter_if
// Description : Bus bundle between two L1 L2-ports, the port arbiter and the
//               single L2_cache L1-side port.
// Revision    : 1.0 - initial release
// ============================================================================
interface l2_port_arbiter_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 15
);
    // L1 side, bit k / suffix _k belongs to core k
    logic [1:0]        L1_read_request;
    logic [1:0]        L1_write_request;
    logic [ADDR_W-1:0] L1_word_address_0;
    logic [ADDR_W-1:0] L1_word_address_1;
    logic [N-1:0]      L1_wdata_0;
    logic [N-1:0]      L1_wdata_1;
    logic [N-1:0]      L1_rdata;
    logic [1:0]        L1_L2_busy;
    logic [1:0]        L1_flush;
    // L2 side
    logic              L2_read_request;
    logic              L2_write_request;
    logic [ADDR_W-1:0] L2_word_address;
    logic [N-1:0]      L2_wdata;
    logic [N-1:0]      L2_rdata;
    logic              L2_busy;
    logic              flush;

    modport slave (
        input  L1_read_request, L1_write_request,
        input  L1_word_address_0, L1_word_address_1,
        input  L1_wdata_0, L1_wdata_1,
        output L1_rdata, L1_L2_busy, L1_flush,
        output L2_read_request, L2_write_request, L2_word_address, L2_wdata,
        input  L2_rdata, L2_busy, flush
    );

    modport master (
        output L1_read_request, L1_write_request,
        output L1_word_address_0, L1_word_address_1,
        output L1_wdata_0, L1_wdata_1,
        input  L1_rdata, L1_L2_busy, L1_flush,
        input  L2_read_request, L2_write_request, L2_word_address, L2_wdata,
        output L2_rdata, L2_busy, flush
    );
endinterface
`default_nettype wire

// File: rtl/l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l2_port_arbiter
// Description : Round-robin arbiter sharing one L2_cache port between two
//               L1_cache instances, one whole transaction per grant.
//               Define ARB_FIXED_PRIORITY_EN to make core0 always win ties.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_port_arbiter #(
    parameter int N      = 32,
    parameter int ADDR_W = 15
) (
    input  wire logic         clk,
    input  wire logic         reset,
    l2_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SERVE = 2'd2,
        ST_REL   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_grant;
    logic              w_grant_nxt;
    logic              r_ptr;
    logic              w_ptr_nxt;
    logic              r_l2_rd;
    logic              w_l2_rd_nxt;
    logic              r_l2_wr;
    logic              w_l2_wr_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [N-1:0]      r_wdata;
    logic [N-1:0]      w_wdata_nxt;

    logic [1:0]        w_pending;
    logic              w_winner;
    logic              w_done_0;
    logic              w_done_1;

    assign w_pending = bus.L1_read_request | bus.L1_write_request;

    // Tie goes to the pointer core; a lone pending core wins outright.
    assign w_winner  = (w_pending == 2'b11) ? r_ptr : w_pending[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_l2_rd_nxt = r_l2_rd;
        w_l2_wr_nxt = r_l2_wr;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        case (r_state)
            ST_IDLE: begin
                if (|w_pending) begin
                    w_grant_nxt = w_winner;
                    // A simultaneous read+write is forwarded as a write only.
                    w_l2_wr_nxt = bus.L1_write_request[w_winner];
                    w_l2_rd_nxt = bus.L1_read_request[w_winner] &
                                  ~bus.L1_write_request[w_winner];
                    w_addr_nxt  = w_winner ? bus.L1_word_address_1 : bus.L1_word_address_0;
                    w_wdata_nxt = w_winner ? bus.L1_wdata_1 : bus.L1_wdata_0;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // L2 has sampled the request once it reports busy.
                if (bus.L2_busy) begin
                    w_l2_rd_nxt = 1'b0;
                    w_l2_wr_nxt = 1'b0;
                    w_state_nxt = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (!bus.L2_busy) begin
                    w_state_nxt = ST_REL;
                end
            end
            ST_REL: begin
                // No arbitration here, so the finished core may drop its request.
`ifdef ARB_FIXED_PRIORITY_EN
                w_ptr_nxt   = 1'b0;
`else
                w_ptr_nxt   = ~r_grant;
`endif
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant <= 1'b0;
            r_ptr   <= 1'b0;
            r_l2_rd <= 1'b0;
            r_l2_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_l2_rd <= w_l2_rd_nxt;
            r_l2_wr <= w_l2_wr_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign w_done_0 = (r_state == ST_SERVE) && !r_grant && !bus.L2_busy;
    assign w_done_1 = (r_state == ST_SERVE) &&  r_grant && !bus.L2_busy;

    assign bus.L1_L2_busy       = w_pending & ~{w_done_1, w_done_0};
    assign bus.L1_rdata         = bus.L2_rdata;
    assign bus.L1_flush         = {bus.flush, bus.flush};
    assign bus.L2_read_request  = r_l2_rd;
    assign bus.L2_write_request = r_l2_wr;
    assign bus.L2_word_address  = r_addr;
    assign bus.L2_wdata         = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_port_arbiter
// Description : Directed scoreboard bench for l2_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_port_arbiter;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [14:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    txn_t sb[$];

    l2_port_arbiter_if #(.N(32), .ADDR_W(15)) bus();

    l2_port_arbiter #(.N(32), .ADDR_W(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic rd, input logic wr, input logic [14:0] addr,
                        input logic [31:0] wd);
        txn_t t;
        t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wd;
        sb.push_back(t);
    endtask

    task automatic core_req(input int k, input logic rd, input logic wr,
                            input logic [14:0] addr, input logic [31:0] wd);
        bus.L1_read_request[k]  = rd;
        bus.L1_write_request[k] = wr;
        if (k == 0) begin
            bus.L1_word_address_0 = addr;
            bus.L1_wdata_0        = wd;
        end else begin
            bus.L1_word_address_1 = addr;
            bus.L1_wdata_1        = wd;
        end
    endtask

    // Wait (bounded) for a downstream request and compare it to the scoreboard head.
    task automatic wait_req(input int g, output bit ok);
        txn_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.L2_read_request | bus.L2_write_request;
        end
        check("l2_req_seen", {63'b0, seen}, 64'd1);
        ok = seen && (sb.size() != 0);
        if (seen) check("sb_nonempty", {63'b0, sb.size() != 0}, 64'd1);
        if (!ok) return;
        e = sb.pop_front();
        check("l2_rd",    {63'b0, bus.L2_read_request},  {63'b0, e.rd});
        check("l2_wr",    {63'b0, bus.L2_write_request}, {63'b0, e.wr});
        check("l2_addr",  {49'b0, bus.L2_word_address},  {49'b0, e.addr});
        check("l2_wdata", {32'b0, bus.L2_wdata},         {32'b0, e.wdata});
        if (bus.L1_read_request[1-g] | bus.L1_write_request[1-g])
            check("other_busy", {63'b0, bus.L1_L2_busy[1-g]}, 64'd1);
    endtask

    task automatic l2_txn(input int busy_cycles, input logic [31:0] rdata, input int g,
                          input logic [1:0] drop_mask);
        bit ok;
        wait_req(g, ok);
        if (!ok) return;
        bus.L2_busy = 1'b1;
        for (int i = 1; i < busy_cycles; i++) begin
            @(negedge clk);
            check("granted_busy", {63'b0, bus.L1_L2_busy[g]}, 64'd1);
            check("req_dropped", {63'b0, bus.L2_read_request | bus.L2_write_request}, 64'd0);
            if (bus.L1_read_request[1-g] | bus.L1_write_request[1-g])
                check("other_busy", {63'b0, bus.L1_L2_busy[1-g]}, 64'd1);
        end
        @(negedge clk);
        bus.L2_busy  = 1'b0;
        bus.L2_rdata = rdata;
        #1;
        check("granted_done", {63'b0, bus.L1_L2_busy[g]}, 64'd0);
        check("l1_rdata", {32'b0, bus.L1_rdata}, {32'b0, rdata});
        bus.L1_read_request  = bus.L1_read_request  & ~drop_mask;
        bus.L1_write_request = bus.L1_write_request & ~drop_mask;
        @(negedge clk);
        check("rel_req_low", {63'b0, bus.L2_read_request | bus.L2_write_request}, 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", fails);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.L1_read_request   = 2'b00;
        bus.L1_write_request  = 2'b00;
        bus.L1_word_address_0 = '0;
        bus.L1_word_address_1 = '0;
        bus.L1_wdata_0        = '0;
        bus.L1_wdata_1        = '0;
        bus.L2_rdata          = '0;
        bus.L2_busy           = 1'b0;
        bus.flush             = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd",    {63'b0, bus.L2_read_request},  64'd0);
        check("rst_wr",    {63'b0, bus.L2_write_request}, 64'd0);
        check("rst_addr",  {49'b0, bus.L2_word_address},  64'd0);
        check("rst_wdata", {32'b0, bus.L2_wdata},         64'd0);
        check("rst_busy",  {62'b0, bus.L1_L2_busy},       64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: single read from core0
        core_req(0, 1'b1, 1'b0, 15'h0040, 32'h0);
        push(1'b1, 1'b0, 15'h0040, 32'h0);
        #1;
        check("t1_not_yet", {63'b0, bus.L2_read_request}, 64'd0);
        check("t1_busy0",   {63'b0, bus.L1_L2_busy[0]},   64'd1);
        l2_txn(3, 32'hDEADBEEF, 0, 2'b01);

        // 2: simultaneous writes, core0 first
        do_reset();
        core_req(0, 1'b0, 1'b1, 15'h0010, 32'h11111111);
        core_req(1, 1'b0, 1'b1, 15'h0020, 32'h22222222);
        push(1'b0, 1'b1, 15'h0010, 32'h11111111);
        push(1'b0, 1'b1, 15'h0020, 32'h22222222);
        l2_txn(2, 32'h0, 0, 2'b01);
        l2_txn(2, 32'h0, 1, 2'b10);

        // 3: both continuously pending for six transactions
        core_req(0, 1'b1, 1'b0, 15'h0100, 32'h0);
        core_req(1, 1'b1, 1'b0, 15'h0200, 32'h0);
        for (int t = 0; t < 6; t++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            push(1'b1, 1'b0, 15'h0100, 32'h0);
`else
            push(1'b1, 1'b0, (t % 2 == 0) ? 15'h0100 : 15'h0200, 32'h0);
`endif
        end
        for (int t = 0; t < 6; t++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            l2_txn(1 + t % 2, 32'h100 + t, 0, (t == 5) ? 2'b11 : 2'b00);
`else
            l2_txn(1 + t % 2, 32'h100 + t, t % 2, (t == 5) ? 2'b11 : 2'b00);
`endif
        end

        // 4: read+write together forwards only the write
        core_req(1, 1'b1, 1'b1, 15'h0005, 32'hA5A5A5A5);
        push(1'b0, 1'b1, 15'h0005, 32'hA5A5A5A5);
        l2_txn(1, 32'h0, 1, 2'b10);

        // 5: reset in SERVE, then lone core1 wins
        core_req(0, 1'b0, 1'b1, 15'h0030, 32'h00000055);
        push(1'b0, 1'b1, 15'h0030, 32'h00000055);
        wait_req(0, ok);
        bus.L2_busy = 1'b1;
        @(negedge clk);
        check("t5_serve_busy", {63'b0, bus.L1_L2_busy[0]}, 64'd1);
        reset = 1'b1;
        core_req(0, 1'b0, 1'b0, 15'h0, 32'h0);
        core_req(1, 1'b1, 1'b0, 15'h0077, 32'h0);
        @(negedge clk);
        check("t5_rst_wr",    {63'b0, bus.L2_write_request}, 64'd0);
        check("t5_rst_rd",    {63'b0, bus.L2_read_request},  64'd0);
        check("t5_rst_addr",  {49'b0, bus.L2_word_address},  64'd0);
        check("t5_rst_wdata", {32'b0, bus.L2_wdata},         64'd0);
        reset       = 1'b0;
        bus.L2_busy = 1'b0;
        push(1'b1, 1'b0, 15'h0077, 32'h0);
        l2_txn(2, 32'h12345678, 1, 2'b10);

        // 6: flush pulse mid-transaction
        core_req(0, 1'b0, 1'b1, 15'h0066, 32'hCAFEF00D);
        push(1'b0, 1'b1, 15'h0066, 32'hCAFEF00D);
        @(negedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("t6_flush_on", {62'b0, bus.L1_flush}, 64'd3);
        check("t6_req_held", {63'b0, bus.L2_write_request}, 64'd1);
        bus.flush = 1'b0;
        #1;
        check("t6_flush_off", {62'b0, bus.L1_flush}, 64'd0);
        l2_txn(2, 32'h0, 0, 2'b01);

        check("sb_drained", {32'b0, sb.size()}, 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
